// File: rtl/piece_sequencer.sv
// Piece sequencer: fetches 7-piece bags from the bag generator, validates them,
// and serves the head piece plus a one-piece preview from an active/pending slot pair.
module piece_sequencer #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic            newbag,
  input  logic            bag_ready,
  input  logic [20:0]     bag,
  input  logic            piece_req,
  output logic [2:0]      piece,
  output logic            piece_valid,
  output logic [2:0]      preview,
  output logic            preview_valid,
  output logic            bag_err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t      state_r;
  logic [20:0] act_r, pend_r, stage_r;
  logic [2:0]  idx_r;
  logic [3:0]  cnt_r;
  logic        pend_full_r;
  logic        ready_d_r;

  logic [20:0] act_s, pend_s;
  logic [2:0]  idx_s;
  logic [3:0]  cnt_s;
  logic        pend_full_s;
  logic        consume_s;
  logic        stage_ok_s;
  logic        load_s;
  logic [2:0]  piece_s, preview_s;
  logic        piece_valid_s, preview_valid_s;

  function automatic logic [2:0] get_entry(input logic [20:0] b, input logic [2:0] k);
    case (k)
      3'd0:    get_entry = b[2:0];
      3'd1:    get_entry = b[5:3];
      3'd2:    get_entry = b[8:6];
      3'd3:    get_entry = b[11:9];
      3'd4:    get_entry = b[14:12];
      3'd5:    get_entry = b[17:15];
      3'd6:    get_entry = b[20:18];
      default: get_entry = 3'd0;
    endcase
  endfunction

  // A code of 7 sets bit 7, so only a true permutation of 0..6 yields exactly 8'h7F.
  function automatic logic bag_is_perm(input logic [20:0] b);
    logic [7:0] seen;
    seen = 8'd0;
    for (int k = 0; k < 7; k++) begin
      seen = seen | (8'd1 << get_entry(b, 3'(k)));
    end
    bag_is_perm = (seen == 8'h7F);
  endfunction

  assign consume_s  = piece_req && (cnt_r != 4'd0);
  assign stage_ok_s = bag_is_perm(stage_r);
  assign load_s     = (state_r == CHECK) && stage_ok_s;

  // Next slot state: consume (with swap from pending), then accept a validated bag.
  always_comb begin
    act_s       = act_r;
    pend_s      = pend_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    pend_full_s = pend_full_r;
    if (consume_s) begin
      if ((cnt_r == 4'd1) && pend_full_r) begin
        act_s       = pend_r;
        idx_s       = 3'd0;
        cnt_s       = 4'd7;
        pend_full_s = 1'b0;
      end else begin
        idx_s = idx_r + 3'd1;
        cnt_s = cnt_r - 4'd1;
      end
    end else begin
      cnt_s = cnt_r;
    end
    if (load_s) begin
      if (cnt_s == 4'd0) begin
        act_s = stage_r;
        idx_s = 3'd0;
        cnt_s = 4'd7;
      end else begin
        pend_s      = stage_r;
        pend_full_s = 1'b1;
      end
    end else begin
      pend_full_s = pend_full_s;
    end
  end

  // Head and preview values derived from the next slot state so outputs can be registered.
  always_comb begin
    piece_s         = 3'd0;
    piece_valid_s   = 1'b0;
    preview_s       = 3'd0;
    preview_valid_s = 1'b0;
    if (cnt_s != 4'd0) begin
      piece_valid_s = 1'b1;
      piece_s       = get_entry(act_s, idx_s);
    end else begin
      piece_valid_s = 1'b0;
    end
    if (cnt_s >= 4'd2) begin
      preview_valid_s = 1'b1;
      preview_s       = get_entry(act_s, idx_s + 3'd1);
    end else if ((cnt_s == 4'd1) && pend_full_s) begin
      preview_valid_s = 1'b1;
      preview_s       = get_entry(pend_s, 3'd0);
    end else begin
      preview_valid_s = 1'b0;
      preview_s       = 3'd0;
    end
  end

  // Slot storage and registered serving outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_r         <= 21'd0;
      pend_r        <= 21'd0;
      idx_r         <= 3'd0;
      cnt_r         <= 4'd0;
      pend_full_r   <= 1'b0;
      piece         <= 3'd0;
      piece_valid   <= 1'b0;
      preview       <= 3'd0;
      preview_valid <= 1'b0;
    end else begin
      act_r         <= act_s;
      pend_r        <= pend_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      pend_full_r   <= pend_full_s;
      piece         <= piece_s;
      piece_valid   <= piece_valid_s;
      preview       <= preview_s;
      preview_valid <= preview_valid_s;
    end
  end

  // Fetch FSM: newbag is registered, so it is raised on every transition into REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      newbag    <= 1'b0;
      stage_r   <= 21'd0;
      ready_d_r <= 1'b0;
      bag_err   <= 1'b0;
      err_count <= {ERRW{1'b0}};
    end else begin
      ready_d_r <= bag_ready;
      newbag    <= 1'b0;
      bag_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if ((cnt_r == 4'd0) || !pend_full_r) begin
            state_r <= REQ;
            newbag  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (bag_ready && !ready_d_r) begin
            stage_r <= bag;
            state_r <= CHECK;
          end else begin
            state_r <= WAIT;
          end
        end
        CHECK: begin
          if (stage_ok_s) begin
            state_r <= IDLE;
          end else begin
            bag_err <= 1'b1;
            if (err_count != {ERRW{1'b1}}) begin
              err_count <= err_count + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
              err_count <= err_count;
            end
            state_r <= REQ;
            newbag  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed self-checking bench for piece_sequencer: bag fetch, validation,
// serving across bag boundaries, stalls, level-high bag_ready and reset mid-fetch.
module tb_piece_sequencer;

  logic        clk;
  logic        reset;
  logic        newbag;
  logic        bag_ready;
  logic [20:0] bag;
  logic        piece_req;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [2:0]  preview;
  logic        preview_valid;
  logic        bag_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  piece_sequencer #(.ERRW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .newbag       (newbag),
    .bag_ready    (bag_ready),
    .bag          (bag),
    .piece_req    (piece_req),
    .piece        (piece),
    .piece_valid  (piece_valid),
    .preview      (preview),
    .preview_valid(preview_valid),
    .bag_err      (bag_err),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until newbag is seen high; n is the number of cycles waited.
  task automatic wait_newbag(output int n);
    n = 0;
    while ((newbag !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
  endtask

  // Starts from the cycle newbag is high (FSM in REQ); ends right after the CHECK edge.
  task automatic deliver(input logic [20:0] b);
    tick();
    bag       = b;
    bag_ready = 1'b1;
    tick();
    bag_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; bag_ready = 1'b0; bag = 21'd0; piece_req = 1'b0;
    tick(); tick();
    checks++; if (piece_valid !== 1'b0 || piece !== 3'd0) begin errors++; $display("FAIL reset_piece: got valid=%0b piece=%0d expected 0/0", piece_valid, piece); end
    checks++; if (preview_valid !== 1'b0 || preview !== 3'd0) begin errors++; $display("FAIL reset_preview: got valid=%0b preview=%0d expected 0/0", preview_valid, preview); end
    checks++; if (newbag !== 1'b0 || bag_err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_ctl: got newbag=%0b bag_err=%0b err_count=%0d expected 0/0/0", newbag, bag_err, err_count); end
    reset = 1'b0;
    wait_newbag(n);
    checks++; if (newbag !== 1'b1 || n != 1) begin errors++; $display("FAIL reset_first_newbag: got newbag=%0b after %0d cycles expected 1 after 1", newbag, n); end
  endtask

  task automatic test_first_bag();
    int n;
    tick();
    bag = 21'o6543210; bag_ready = 1'b1;
    tick();
    bag_ready = 1'b0;
    checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %0b expected 0", piece_valid); end
    tick();
    checks++; if (piece_valid !== 1'b1 || piece !== 3'd0) begin errors++; $display("FAIL first_piece: got valid=%0b piece=%0d expected 1/0", piece_valid, piece); end
    checks++; if (preview_valid !== 1'b1 || preview !== 3'd1) begin errors++; $display("FAIL first_preview: got valid=%0b preview=%0d expected 1/1", preview_valid, preview); end
    wait_newbag(n);
    checks++; if (newbag !== 1'b1 || n != 1) begin errors++; $display("FAIL second_newbag: got newbag=%0b after %0d cycles expected 1 after 1", newbag, n); end
    deliver(21'o0123456);
    checks++; if (piece !== 3'd0 || preview !== 3'd1 || bag_err !== 1'b0) begin errors++; $display("FAIL pending_load: got piece=%0d preview=%0d bag_err=%0b expected 0/1/0", piece, preview, bag_err); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (newbag !== 1'b0) begin errors++; $display("FAIL no_third_request: cycle %0d got newbag=%0b expected 0", i, newbag); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    piece_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (piece_valid !== 1'b1 || piece !== 3'(i)) begin errors++; $display("FAIL b2b_piece: step %0d got valid=%0b piece=%0d expected 1/%0d", i, piece_valid, piece, i); end
      checks++; if (preview_valid !== 1'b1 || preview !== ((i < 6) ? 3'(i + 1) : 3'd6)) begin errors++; $display("FAIL b2b_preview: step %0d got valid=%0b preview=%0d expected 1/%0d", i, preview_valid, preview, (i < 6) ? i + 1 : 6); end
      tick();
    end
    piece_req = 1'b0;
    checks++; if (piece_valid !== 1'b1 || piece !== 3'd6 || preview !== 3'd5) begin errors++; $display("FAIL b2b_swap: got valid=%0b piece=%0d preview=%0d expected 1/6/5", piece_valid, piece, preview); end
    wait_newbag(n);
    checks++; if (newbag !== 1'b1 || n != 1) begin errors++; $display("FAIL b2b_refetch: got newbag=%0b after %0d cycles expected 1 after 1", newbag, n); end
  endtask

  task automatic test_bad_bag();
    deliver(21'o0543210);
    checks++; if (bag_err !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL bad_bag_err: got bag_err=%0b err_count=%0d expected 1/1", bag_err, err_count); end
    checks++; if (newbag !== 1'b1 || piece !== 3'd6) begin errors++; $display("FAIL bad_bag_retry: got newbag=%0b piece=%0d expected 1/6", newbag, piece); end
    deliver(21'o1032546);
    checks++; if (bag_err !== 1'b0 || err_count !== 8'd1 || preview !== 3'd5) begin errors++; $display("FAIL good_after_bad: got bag_err=%0b err_count=%0d preview=%0d expected 0/1/5", bag_err, err_count, preview); end
    tick(); tick();
    checks++; if (newbag !== 1'b0) begin errors++; $display("FAIL good_after_bad_idle: got newbag=%0b expected 0", newbag); end
  endtask

  task automatic test_stall();
    logic [2:0] s1 [7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [2:0] s2 [7] = '{3'd6, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};
    piece_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (piece !== s1[i] || preview !== ((i < 6) ? s1[i + 1] : 3'd6)) begin errors++; $display("FAIL stall_run1: step %0d got piece=%0d preview=%0d expected %0d/%0d", i, piece, preview, s1[i], (i < 6) ? s1[i + 1] : 3'd6); end
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (piece_valid !== 1'b1 || piece !== s2[i] || preview_valid !== (i < 6)) begin errors++; $display("FAIL stall_run2: step %0d got valid=%0b piece=%0d pv=%0b expected 1/%0d/%0b", i, piece_valid, piece, preview_valid, s2[i], i < 6); end
      tick();
    end
    tick(); tick();
    checks++; if (piece_valid !== 1'b0 || piece !== 3'd0 || preview_valid !== 1'b0 || preview !== 3'd0) begin errors++; $display("FAIL stall_empty: got valid=%0b piece=%0d pv=%0b preview=%0d expected 0/0/0/0", piece_valid, piece, preview_valid, preview); end
    piece_req = 1'b0;
    bag = 21'o6543210; bag_ready = 1'b1;
    tick();
    bag_ready = 1'b0;
    tick();
    checks++; if (piece_valid !== 1'b1 || piece !== 3'd0 || preview !== 3'd1) begin errors++; $display("FAIL stall_arrival: got valid=%0b piece=%0d preview=%0d expected 1/0/1", piece_valid, piece, preview); end
  endtask

  task automatic test_hold_high();
    int n;
    bag = 21'o0543210; bag_ready = 1'b1;
    wait_newbag(n);
    checks++; if (newbag !== 1'b1 || n != 1) begin errors++; $display("FAIL hold_newbag: got newbag=%0b after %0d cycles expected 1 after 1", newbag, n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bag_err !== 1'b0 || newbag !== 1'b0 || err_count !== 8'd1) begin errors++; $display("FAIL hold_no_capture: cycle %0d got bag_err=%0b newbag=%0b err_count=%0d expected 0/0/1", i, bag_err, newbag, err_count); end
    end
    bag_ready = 1'b0;
    tick();
    bag = 21'o0123456; bag_ready = 1'b1;
    tick();
    bag_ready = 1'b0;
    tick();
    checks++; if (bag_err !== 1'b0 || err_count !== 8'd1) begin errors++; $display("FAIL hold_recapture: got bag_err=%0b err_count=%0d expected 0/1", bag_err, err_count); end
    piece_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (piece !== 3'(i)) begin errors++; $display("FAIL hold_consume: step %0d got piece=%0d expected %0d", i, piece, i); end
      tick();
    end
    piece_req = 1'b0;
    checks++; if (piece !== 3'd6 || preview_valid !== 1'b1 || preview !== 3'd6) begin errors++; $display("FAIL hold_pending_preview: got piece=%0d pv=%0b preview=%0d expected 6/1/6", piece, preview_valid, preview); end
  endtask

  task automatic test_reset_wait();
    int n;
    piece_req = 1'b1;
    tick();
    piece_req = 1'b0;
    checks++; if (piece !== 3'd6 || preview !== 3'd5) begin errors++; $display("FAIL rw_swap: got piece=%0d preview=%0d expected 6/5", piece, preview); end
    wait_newbag(n);
    tick();
    reset = 1'b1;
    tick();
    checks++; if (piece_valid !== 1'b0 || piece !== 3'd0 || preview_valid !== 1'b0 || preview !== 3'd0) begin errors++; $display("FAIL rw_outputs: got valid=%0b piece=%0d pv=%0b preview=%0d expected 0/0/0/0", piece_valid, piece, preview_valid, preview); end
    checks++; if (newbag !== 1'b0 || bag_err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL rw_ctl: got newbag=%0b bag_err=%0b err_count=%0d expected 0/0/0", newbag, bag_err, err_count); end
    reset = 1'b0;
    tick();
    checks++; if (newbag !== 1'b1) begin errors++; $display("FAIL rw_newbag: got %0b expected 1", newbag); end
    tick();
    checks++; if (newbag !== 1'b0 || bag_err !== 1'b0) begin errors++; $display("FAIL rw_pulse: got newbag=%0b bag_err=%0b expected 0/0", newbag, bag_err); end
  endtask

  initial begin
    test_reset();
    test_first_bag();
    test_back_to_back();
    test_bad_bag();
    test_stall();
    test_hold_high();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
